// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - op codes, BHT encodings and counter update helper
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    BJ_BEQ  = 3'b000,
    BJ_BNE  = 3'b001,
    BJ_JUMP = 3'b010,
    BJ_NONE = 3'b011,
    BJ_BLT  = 3'b100,
    BJ_BGE  = 3'b101,
    BJ_BLTU = 3'b110,
    BJ_BGEU = 3'b111
  } bj_op_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  function automatic logic [1:0] bht_next(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    nxt = state;
    if (taken && state != ST) nxt = state + 2'd1;
    else if (!taken && state != SNT) nxt = state - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - IF lookup, EX resolve and redirect signal bundle
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  lookup_pc;
  logic             pred_taken;
  logic             res_valid;
  logic             stall;
  logic [2:0]       branch_jump;
  logic [XLEN-1:0]  data1;
  logic [XLEN-1:0]  data2;
  logic [XLEN-1:0]  res_pc;
  logic [XLEN-1:0]  target;
  logic             pred_in;
  logic             pc_sel;
  logic [XLEN-1:0]  pc_target;
  logic             flush;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output lookup_pc, res_valid, stall, branch_jump, data1, data2, res_pc, target, pred_in,
    input  pred_taken, pc_sel, pc_target, flush, br_count, miss_count
  );

  modport slave (
    input  lookup_pc, res_valid, stall, branch_jump, data1, data2, res_pc, target, pred_in,
    output pred_taken, pc_sel, pc_target, flush, br_count, miss_count
  );
endinterface

// File: rtl/branch_resolve_unit_compare.sv
// rtl/branch_resolve_unit_compare.sv - combinational branch condition evaluation
module branch_resolve_unit_compare
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  bj_op_e          op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      BJ_BEQ:  taken = (data1 == data2);
      BJ_BNE:  taken = (data1 != data2);
      BJ_BLT:  taken = ($signed(data1) <  $signed(data2));
      BJ_BGE:  taken = ($signed(data1) >= $signed(data2));
      BJ_BLTU: taken = (data1 <  data2);
      BJ_BGEU: taken = (data1 >= data2);
      BJ_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolver with BHT predictor and registered redirect
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input logic                clk,
  input logic                reset,
  branch_resolve_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bj_op_e                   op;
  logic                     taken;
  logic                     miss;
  logic                     accept;
  logic                     is_cond;
  logic [IDX_W-1:0]         lookup_idx;
  logic [IDX_W-1:0]         res_idx;
  logic [1:0]               res_state;
  logic [2*BHT_ENTRIES-1:0] bht_q;
  logic                     pc_sel_q;
  logic [XLEN-1:0]          pc_target_q;
  logic [CNT_W-1:0]         br_q;
  logic [CNT_W-1:0]         miss_q;
  logic                     unused_lookup;

  assign op            = bj_op_e'(bus.branch_jump);
  assign lookup_idx    = bus.lookup_pc[IDX_W+1:2];
  assign res_idx       = bus.res_pc[IDX_W+1:2];
  assign res_state     = bht_q[{res_idx, 1'b0} +: 2];
  assign unused_lookup = ^{bus.lookup_pc[XLEN-1:IDX_W+2], bus.lookup_pc[1:0]};

  // Read sees the pre-edge array, so a same-cycle update shows up one cycle later.
  assign bus.pred_taken = bht_q[{lookup_idx, 1'b1}];

  branch_resolve_unit_compare #(.XLEN(XLEN)) u_compare (
    .op    (op),
    .data1 (bus.data1),
    .data2 (bus.data2),
    .taken (taken)
  );

  // The cycle that carries a redirect holds a wrong-path instruction in EX.
  assign accept  = bus.res_valid & ~bus.stall & ~pc_sel_q & (op != BJ_NONE);
  assign is_cond = (op != BJ_JUMP);
  assign miss    = taken ^ bus.pred_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_sel_q    <= 1'b0;
      pc_target_q <= '0;
      br_q        <= '0;
      miss_q      <= '0;
      bht_q       <= {BHT_ENTRIES{WNT}};
    end else if (!bus.stall) begin
      pc_sel_q <= accept & miss;
      if (accept) begin
        pc_target_q <= taken ? bus.target : bus.res_pc + XLEN'(4);
        if (br_q != '1) br_q <= br_q + CNT_W'(1);
        if (miss && miss_q != '1) miss_q <= miss_q + CNT_W'(1);
        if (is_cond) bht_q[{res_idx, 1'b0} +: 2] <= bht_next(res_state, taken);
      end
    end
  end

  assign bus.pc_sel     = pc_sel_q;
  assign bus.flush      = pc_sel_q;
  assign bus.pc_target  = pc_target_q;
  assign bus.br_count   = br_q;
  assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) bus ();

  branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what the pipeline should observe after each edge.
  int          m_bht[16];
  logic        m_sel;
  logic [31:0] m_tgt;
  int          m_br;
  int          m_miss;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
    logic        exp_sel;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return 1'b1;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_pred(input logic [31:0] lpc);
    return m_bht[(lpc >> 2) % 16] >= 2;
  endfunction

  task automatic model_step();
    bit t;
    int idx;
    if (rst) begin
      m_sel = 0; m_tgt = 0; m_br = 0; m_miss = 0;
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
    end else if (!bus.stall) begin
      if (bus.res_valid && !m_sel && bus.branch_jump != 3'd3) begin
        t     = ref_taken(bus.branch_jump, bus.data1, bus.data2);
        m_sel = (t != bus.pred_in);
        m_tgt = t ? bus.target : bus.res_pc + 32'd4;
        if (m_br != 65535) m_br++;
        if (m_sel && m_miss != 65535) m_miss++;
        if (bus.branch_jump != 3'd2) begin
          idx = (bus.res_pc >> 2) % 16;
          if (t && m_bht[idx] < 3) m_bht[idx]++;
          else if (!t && m_bht[idx] > 0) m_bht[idx]--;
        end
      end else begin
        m_sel = 0;
      end
    end
  endtask

  // Inputs are set on the falling edge; outputs are compared on the next falling edge.
  task automatic cycle(input bit chk);
    #1;
    if (chk) check("pred_taken", bus.pred_taken, ref_pred(bus.lookup_pc));
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (chk) begin
      check("pc_sel", bus.pc_sel, m_sel);
      check("flush", bus.flush, m_sel);
      check("pc_target", bus.pc_target, m_tgt);
      check("br_count", bus.br_count, m_br);
      check("miss_count", bus.miss_count, m_miss);
    end
  endtask

  task automatic drive(input bit v, input bit s, input logic [2:0] op, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] pc, input logic [31:0] tgt, input bit pred);
    bus.res_valid = v;  bus.stall = s;  bus.branch_jump = op;
    bus.data1 = d1;     bus.data2 = d2; bus.res_pc = pc;
    bus.target = tgt;   bus.pred_in = pred;
  endtask

  task automatic idle();
    drive(0, 0, 3'd3, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    cycle(1);
    rst = 0;
  endtask

  logic [31:0] pick[4];

  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    bus.lookup_pc = 0;
    idle();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_sel = 0; m_tgt = 0; m_br = 0; m_miss = 0;
    pick[0] = 32'h0; pick[1] = 32'h1; pick[2] = 32'hFFFF_FFFF; pick[3] = 32'h8000_0000;

    vt[0] = '{3'b000, 32'd5,        32'd5,        32'h100,      32'h200, 1'b0, 1'b1, 32'h200};
    vt[1] = '{3'b100, 32'hFFFFFFFF, 32'd1,        32'h104,      32'h300, 1'b1, 1'b0, 32'h300};
    vt[2] = '{3'b110, 32'hFFFFFFFF, 32'd1,        32'h108,      32'h400, 1'b1, 1'b1, 32'h10C};
    vt[3] = '{3'b101, 32'd1,        32'hFFFFFFFF, 32'h10C,      32'h500, 1'b0, 1'b1, 32'h500};
    vt[4] = '{3'b111, 32'd1,        32'hFFFFFFFF, 32'h110,      32'h600, 1'b0, 1'b0, 32'h114};
    vt[5] = '{3'b001, 32'd7,        32'd7,        32'h114,      32'h700, 1'b0, 1'b0, 32'h118};
    vt[6] = '{3'b010, 32'd0,        32'd0,        32'hFFFFFFFC, 32'h800, 1'b1, 1'b0, 32'h800};
    vt[7] = '{3'b010, 32'd0,        32'd0,        32'hFFFFFFFC, 32'h900, 1'b0, 1'b1, 32'h900};
    vt[8] = '{3'b000, 32'd3,        32'd4,        32'hFFFFFFFC, 32'hA00, 1'b1, 1'b1, 32'h0};
    vt[9] = '{3'b011, 32'd0,        32'd0,        32'h120,      32'hB00, 1'b1, 1'b0, 32'h0};

    @(negedge clk);
    do_reset();
    check("reset_pc_sel", bus.pc_sel, 1'b0);
    check("reset_pc_target", bus.pc_target, 32'h0);
    check("reset_br_count", bus.br_count, 16'h0);

    for (int i = 0; i < 10; i++) begin
      drive(1, 0, vt[i].op, vt[i].d1, vt[i].d2, vt[i].pc, vt[i].tgt, vt[i].pred);
      cycle(1);
      check($sformatf("vec%0d_sel", i), bus.pc_sel, vt[i].exp_sel);
      check($sformatf("vec%0d_target", i), bus.pc_target, vt[i].exp_tgt);
      idle();
      cycle(1);
    end
    check("table_br_count", bus.br_count, 16'd9);
    check("table_miss_count", bus.miss_count, 16'd5);

    // BHT training and aliasing at index 0
    do_reset();
    bus.lookup_pc = 32'h40;
    #1 check("bht_initial", bus.pred_taken, 1'b0);
    drive(1, 0, 3'b001, 1, 2, 32'h40, 32'h1000, 1);
    cycle(1);
    check("bht_after_first", bus.pred_taken, 1'b1);
    bus.lookup_pc = 32'h80;
    #1 check("bht_alias", bus.pred_taken, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1);
    drive(1, 0, 3'b000, 1, 2, 32'h40, 32'h1000, 0);
    cycle(1);
    check("bht_sat_down1", bus.pred_taken, 1'b1);
    cycle(1);
    check("bht_sat_down2", bus.pred_taken, 1'b0);

    // Instruction sitting in EX during the flush cycle is dropped
    idle();
    cycle(1);
    drive(1, 0, 3'b000, 5, 5, 32'h48, 32'h1000, 0);
    cycle(1);
    check("flush_first_sel", bus.pc_sel, 1'b1);
    drive(1, 0, 3'b000, 5, 6, 32'h48, 32'h2000, 1);
    cycle(1);
    check("flush_ignored_sel", bus.pc_sel, 1'b0);
    check("flush_ignored_br", bus.br_count, 16'd7);
    check("flush_ignored_miss", bus.miss_count, 16'd1);
    check("flush_ignored_target", bus.pc_target, 32'h1000);
    bus.lookup_pc = 32'h48;
    #1 check("flush_ignored_bht", bus.pred_taken, 1'b1);

    // Stall freezes a pending mispredict; reset inside a stall clears everything
    idle();
    cycle(1);
    drive(1, 1, 3'b001, 1, 1, 32'h50, 32'h3000, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1);
      check("stall_sel", bus.pc_sel, 1'b0);
      check("stall_br", bus.br_count, 16'd7);
      check("stall_target", bus.pc_target, 32'h1000);
    end
    bus.stall = 0;
    cycle(1);
    check("release_sel", bus.pc_sel, 1'b1);
    check("release_target", bus.pc_target, 32'h54);
    check("release_br", bus.br_count, 16'd8);
    check("release_miss", bus.miss_count, 16'd2);
    bus.stall = 1;
    cycle(1);
    check("stall_holds_flush", bus.flush, 1'b1);
    rst = 1;
    cycle(1);
    rst = 0;
    check("rst_stall_sel", bus.pc_sel, 1'b0);
    check("rst_stall_target", bus.pc_target, 32'h0);
    check("rst_stall_br", bus.br_count, 16'd0);
    check("rst_stall_miss", bus.miss_count, 16'd0);
    #1 check("rst_stall_bht", bus.pred_taken, 1'b0);

    // Randomised traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
            pick[$urandom_range(0, 3)], pick[$urandom_range(0, 3)],
            {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFE, 1'($urandom_range(0, 1)));
      bus.lookup_pc = ($urandom_range(0, 1) == 1) ? bus.res_pc : ({$urandom} & 32'hFFFF_FFFC);
      cycle(1);
    end
    rst = 0;

    // Counter saturation
    do_reset();
    drive(1, 0, 3'b010, 0, 0, 32'h200, 32'h4000, 1);
    for (int n = 0; n < 65537; n++) cycle(0);
    cycle(1);
    check("br_saturated", bus.br_count, 16'hFFFF);
    check("miss_after_jumps", bus.miss_count, 16'h0);
    idle();
    cycle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
